// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types and constants for the pipeline hazard controller.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Controller states: one-cycle pipeline clear, normal run, MDU stall
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MDU_WAIT = 2'd2
    } hz_state_t;

    // Default watchdog limit for an MDU stall, in cycles
    localparam int HZ_MDU_MAX_CYC_DEF = 64;

    // x0 is hard-wired to zero, so a load into it can never create a hazard
    localparam logic [4:0] REG_X0 = 5'd0;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_perf_cnt
//  Purpose  : Stall-cycle and taken-branch-flush performance counters for the
//             hazard controller. Both counters wrap modulo 2^CNT_W.
//             Instantiated only when HAZARD_PERF_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcWrite,
    input  logic             branchFlush,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushCount;

    // Count every frozen-PC cycle and every taken-branch flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (!pcWrite)
                r_stallCycles <= r_stallCycles + 1'b1;
            if (branchFlush)
                r_flushCount  <= r_flushCount + 1'b1;
        end
    end

    assign stallCycles = r_stallCycles;
    assign flushCount  = r_flushCount;

endmodule : hazard_perf_cnt
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Hazard controller for the 5-stage RV32 pipeline. Sequences the
//             one-bubble load-use stall, taken-branch flush and the
//             multi-cycle MDU stall with its watchdog. Control outputs are
//             combinational (zero latency) from state and inputs.
//             Optional macro HAZARD_PERF_CNT_EN adds the stall_cycles and
//             flush_count performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_MAX_CYC = HZ_MDU_MAX_CYC_DEF
`ifdef HAZARD_PERF_CNT_EN
   ,parameter int CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_hold,
    output logic             ex_mem_bubble,
    output logic             mdu_abort,
    output logic             mdu_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0] stall_cycles
   ,output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int c_CNT_W = $clog2(MDU_MAX_CYC);
    // The start cycle is the first stall cycle, so the watchdog fires on the
    // wait cycle whose count value is MDU_MAX_CYC-2 (the counter would be
    // stepping to MDU_MAX_CYC-1), giving MDU_MAX_CYC stall cycles in total.
    localparam logic [c_CNT_W-1:0] c_ABORT_AT = c_CNT_W'(MDU_MAX_CYC - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = {c_CNT_W{1'b1}};

    hz_state_t          r_state;
    hz_state_t          w_nextState;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic [c_CNT_W-1:0] w_nextCnt;
    logic               r_timeout;
    logic               w_loadUse;
    logic               w_abort;

    // Load in EX feeding a source operand of the instruction in ID
    always_comb begin
        w_loadUse = id_ex_memread && (id_ex_rd != REG_X0) &&
                    ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == id_ex_rd)));
    end

    // State, wait counter and sticky watchdog flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= INIT;
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextCnt;
            if (w_abort)
                r_timeout <= 1'b1;
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = r_waitCnt;
        w_abort       = 1'b0;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_bubble = 1'b0;

        case (r_state)
            INIT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                w_nextState = RUN;
            end

            RUN: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if (ex_branch_taken) begin
                    // Wrong-path instructions in IF and ID are discarded;
                    // MDU start and load-use belong to squashed work.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ex_mdu_start && !mdu_done) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                    w_nextState   = MDU_WAIT;
                    w_nextCnt     = '0;
                end else if (ex_mdu_start && mdu_done) begin
                    // Single-cycle MDU result: nothing to wait for
                end else if (w_loadUse) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end

            MDU_WAIT: begin
                if (mdu_done) begin
                    // Release the stall in the same cycle the result lands
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    w_nextState = RUN;
                end else begin
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                    if (r_waitCnt == c_ABORT_AT) begin
                        w_abort     = 1'b1;
                        w_nextState = RUN;
                    end else if (r_waitCnt != c_CNT_SAT) begin
                        w_nextCnt = r_waitCnt + 1'b1;
                    end
                end
            end

            default: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                w_nextState = INIT;
            end
        endcase
    end

    assign mdu_abort   = w_abort;
    assign mdu_timeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic w_branchFlush;
    assign w_branchFlush = (r_state == RUN) && ex_branch_taken;

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perfCnt (
        .clk         (clk),
        .rst         (rst),
        .pcWrite     (pc_write),
        .branchFlush (w_branchFlush),
        .stallCycles (stall_cycles),
        .flushCount  (flush_count)
    );
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It issues the stall, hold and flush controls for the pipeline registers: a one-bubble load-use stall, a taken-branch flush, and a multi-cycle stall while the multi-cycle MUL/DIV unit (MDU) works, with a watchdog on that stall. It sits beside the forwarding unit. Forwarding covers every RAW hazard except load-use and MDU latency, and this block sequences those two.

## Interface
- MDU_MAX_CYC, 64: maximum MDU_WAIT cycles before the watchdog fires (≥2).
- CNT_W, 32: performance counter width (used only with the macro).
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads rs1 / rs2.
- id_ex_memread  in  1  the instruction in EX is a load.
- id_ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- ex_mdu_start  in  1  MDU op entering execution in EX (1-cycle pulse).
- mdu_done  in  1  MDU result valid.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID may load.
- if_id_flush  out  1  zero IF/ID next edge.
- id_ex_flush  out  1  load a bubble into ID/EX next edge.
- id_ex_hold  out  1  ID/EX keeps its contents.
- ex_mem_bubble  out  1  load a bubble into EX/MEM next edge.
- mdu_abort  out  1  1-cycle pulse that kills the MDU on watchdog.
- mdu_timeout  out  1  sticky watchdog flag, cleared only by rst.
- stall_cycles, flush_count  out  CNT_W each  present only with the macro.

## Operation
- FSM states:
  - INIT: first cycle after reset. Asserts if_id_flush=id_ex_flush=1, pc_write=0, if_id_write=0. Always goes to RUN.
  - RUN: normal operation.
  - MDU_WAIT: multi-cycle MDU stall.
- Default outputs in RUN: pc_write=1, if_id_write=1, all others 0.
- load_use = id_ex_memread && id_ex_rd!=0 && ((id_uses_rs1 && id_rs1==id_ex_rd) || (id_uses_rs2 && id_rs2==id_ex_rd)).
- RUN priority, highest first:
  - ex_branch_taken: if_id_flush=1, id_ex_flush=1. Any MDU start or load-use in the same cycle is ignored.
  - ex_mdu_start && !mdu_done: stall this cycle (pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_bubble=1), then go to MDU_WAIT and clear the wait counter.
  - ex_mdu_start && mdu_done: no stall, stay in RUN.
  - load_use: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle, stay in RUN.
- MDU_WAIT:
  - Outputs: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_bubble=1. Branch and load-use inputs are ignored.
  - mdu_done: this cycle takes RUN outputs (stalls released the same cycle), next state RUN.
  - Counter reaches MDU_MAX_CYC-1 without mdu_done: mdu_abort=1 for that cycle, mdu_timeout set, next state RUN.
- Wait counter width is $clog2(MDU_MAX_CYC). It saturates and never wraps.
- Control outputs are combinational from state and inputs. State, counter and mdu_timeout are registered.

## Timing
- Reset (asynchronous, any time including mid-MDU_WAIT):
  - State goes to INIT, counter and mdu_timeout to 0, perf counters to 0.
  - While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, all other outputs 0.
- Stalls and flushes apply at the same clock edge as their cause (latency 0).
- Load-use costs exactly 1 bubble. The forwarding unit covers the load once it reaches MEM/WB.
- An MDU op with mdu_done first seen N cycles after ex_mdu_start costs N stall cycles.
- Watchdog stall cycles = MDU_MAX_CYC: the start cycle plus MDU_MAX_CYC-1 cycles in MDU_WAIT.
- mdu_done outside MDU_WAIT is ignored, except when it coincides with ex_mdu_start in RUN.

## Configuration
- HAZARD_PERF_CNT_EN:
  - Defined: adds stall_cycles (+1 every cycle pc_write=0 while out of reset, INIT included) and flush_count (+1 per taken-branch flush). Both wrap modulo 2^CNT_W.
  - Undefined: the ports and logic are absent.

## Structure
- hazard_pkg:
  - State enum hz_state_t {INIT, RUN, MDU_WAIT}.
  - Default MDU_MAX_CYC.
  - REG_X0 = 5'd0.
- Sub-module hazard_perf_cnt holds both counters and is instantiated only under HAZARD_PERF_CNT_EN.
- Load-use compare and FSM stay in hazard_ctrl.

## Test plan
- Reset release: INIT lasts 1 cycle with both flushes =1, then RUN with pc_write=1.
- Load-use: lw x5 in EX, ID reads x5 via rs2 → exactly 1 cycle of pc_write=0, id_ex_flush=1. Repeat with id_ex_rd=0 → no stall.
- Branch + load-use same cycle: ex_branch_taken=1 with load_use true → if_id_flush=id_ex_flush=1, pc_write=1.
- MDU: ex_mdu_start, mdu_done 5 cycles later → 5 stall cycles, release on the done cycle. Also done coincident with start → 0 stall.
- Watchdog: MDU_MAX_CYC=8, no mdu_done → mdu_abort pulses on the 8th stall cycle, mdu_timeout stays high, RUN resumes.
- rst asserted mid-MDU_WAIT → asynchronous return to INIT, mdu_timeout=0, counters=0 (with HAZARD_PERF_CNT_EN).
